// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions,
// FSM state encoding and the flag-update classes used by the datapath.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADC  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SBC  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_XNOR = 5'd7;
    localparam logic [4:0] OP_BIC  = 5'd8;
    localparam logic [4:0] OP_ORN  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_PASA = 5'd13;
    localparam logic [4:0] OP_PASB = 5'd14;
    localparam logic [4:0] OP_NOTB = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Which flags an op is allowed to touch when set_flags is high.
    typedef enum logic [1:0] {
        UPD_NONE = 2'd0,
        UPD_NZ   = 2'd1,
        UPD_NZC  = 2'd2,
        UPD_NZCV = 2'd3
    } upd_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: bit 0 is folded in on the start edge, the
// remaining WIDTH-1 bits one per cycle; done pulses with the final product.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             active_r;
    logic             done_r;

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= b[0] ? a : '0;
            mcand_r  <= a << 1;
            mplier_r <= b >> 1;
            cnt_r    <= CW'(1);
            active_r <= 1'b1;
            done_r   <= 1'b0;
        end else if (active_r) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
            active_r <= (cnt_r != LAST);
            done_r   <= (cnt_r == LAST);
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, a {Z,N,C,V} flag register and an
// optional multi-cycle multiply handled by alu_seq_mul.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    state_t           state_r, state_next_s;
    logic             accept_s, is_mul_s, mul_start_s, mul_done_s;
    logic [WIDTH-1:0] mul_product_s, alu_res_s, result_r;
    logic [3:0]       flags_r, alu_flags_s;
    logic             setf_r;
    logic [WIDTH:0]   wide_s;
    logic [SW-1:0]    sh_s;
    logic             c_s, v_s;
    upd_t             upd_s;

    assign accept_s    = in_valid && in_ready;
    assign is_mul_s    = (op == OP_MUL) && (MUL_EN != 0);
    assign mul_start_s = accept_s && is_mul_s;
    assign sh_s        = b[SW-1:0];

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start_s),
                .a       (a),
                .b       (b),
                .done    (mul_done_s),
                .product (mul_product_s)
            );
        end else begin : g_nomul
            assign mul_done_s    = 1'b0;
            assign mul_product_s = '0;
        end
    endgenerate

    // Single-cycle ALU result and the carry/overflow it would produce.
    always_comb begin
        alu_res_s = '0;
        wide_s    = '0;
        c_s       = flags_r[FLAG_C];
        v_s       = flags_r[FLAG_V];
        upd_s     = UPD_NONE;
        case (op)
            OP_ADD, OP_ADC: begin
                wide_s    = {1'b0, a} + {1'b0, b}
                          + {{WIDTH{1'b0}}, (op == OP_ADC) ? flags_r[FLAG_C] : 1'b0};
                alu_res_s = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
                upd_s     = UPD_NZCV;
            end
            OP_SUB, OP_SBC: begin
                // Subtract as a + ~b + cin so the carry out is the NOT-borrow.
                wide_s    = {1'b0, a} + {1'b0, ~b}
                          + {{WIDTH{1'b0}}, (op == OP_SBC) ? flags_r[FLAG_C] : 1'b1};
                alu_res_s = wide_s[WIDTH-1:0];
                c_s       = wide_s[WIDTH];
                v_s       = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
                upd_s     = UPD_NZCV;
            end
            OP_AND:  begin alu_res_s = a & b;    upd_s = UPD_NZ; end
            OP_OR:   begin alu_res_s = a | b;    upd_s = UPD_NZ; end
            OP_XOR:  begin alu_res_s = a ^ b;    upd_s = UPD_NZ; end
            OP_XNOR: begin alu_res_s = ~(a ^ b); upd_s = UPD_NZ; end
            OP_BIC:  begin alu_res_s = a & ~b;   upd_s = UPD_NZ; end
            OP_ORN:  begin alu_res_s = a | ~b;   upd_s = UPD_NZ; end
            OP_LSL: begin
                wide_s    = {1'b0, a} << sh_s;
                alu_res_s = wide_s[WIDTH-1:0];
                c_s       = (sh_s == '0) ? flags_r[FLAG_C] : wide_s[WIDTH];
                upd_s     = UPD_NZC;
            end
            OP_LSR: begin
                wide_s    = {a, 1'b0} >> sh_s;
                alu_res_s = wide_s[WIDTH:1];
                c_s       = (sh_s == '0) ? flags_r[FLAG_C] : wide_s[0];
                upd_s     = UPD_NZC;
            end
            OP_ASR: begin
                wide_s    = $signed({a, 1'b0}) >>> sh_s;
                alu_res_s = wide_s[WIDTH:1];
                c_s       = (sh_s == '0) ? flags_r[FLAG_C] : wide_s[0];
                upd_s     = UPD_NZC;
            end
            OP_PASA: begin alu_res_s = a;  upd_s = UPD_NZ; end
            OP_PASB: begin alu_res_s = b;  upd_s = UPD_NZ; end
            OP_NOTB: begin alu_res_s = ~b; upd_s = UPD_NZ; end
            default: begin alu_res_s = '0; upd_s = UPD_NONE; end
        endcase
    end

    // Next flag value for a single-cycle op, masked by the op's update class.
    always_comb begin
        alu_flags_s = flags_r;
        if (set_flags && (upd_s != UPD_NONE)) begin
            alu_flags_s[FLAG_Z] = (alu_res_s == '0);
            alu_flags_s[FLAG_N] = alu_res_s[WIDTH-1];
            if ((upd_s == UPD_NZC) || (upd_s == UPD_NZCV)) begin
                alu_flags_s[FLAG_C] = c_s;
            end else begin
                alu_flags_s[FLAG_C] = flags_r[FLAG_C];
            end
            if (upd_s == UPD_NZCV) begin
                alu_flags_s[FLAG_V] = v_s;
            end else begin
                alu_flags_s[FLAG_V] = flags_r[FLAG_V];
            end
        end else begin
            alu_flags_s = flags_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = is_mul_s ? ST_CALC : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                state_next_s = mul_done_s ? ST_DONE : ST_CALC;
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_next_s = is_mul_s ? ST_CALC : ST_DONE;
                end else if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_CALC: busy = 1'b1;
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Result and flag registers; both load on the edge that completes an op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= '0;
            flags_r  <= 4'b0000;
            setf_r   <= 1'b0;
        end else if (accept_s) begin
            if (is_mul_s) begin
                setf_r <= set_flags;
            end else begin
                result_r <= alu_res_s;
                flags_r  <= alu_flags_s;
            end
        end else if ((state_r == ST_CALC) && mul_done_s) begin
            result_r <= mul_product_s;
            if (setf_r) begin
                flags_r[FLAG_Z] <= (mul_product_s == '0);
                flags_r[FLAG_N] <= mul_product_s[WIDTH-1];
            end else begin
                flags_r <= flags_r;
            end
        end else begin
            result_r <= result_r;
        end
    end

    assign result = result_r;
    assign flags  = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized traffic
// against an arithmetic reference model, checked by an independent monitor.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, set_flags, out_valid, out_ready, busy;
    logic [4:0]   op;
    logic [W-1:0] a, b, result;
    logic [3:0]   flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rand_rdy = 1'b0;
    logic [3:0] mflags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .set_flags(set_flags), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the op definitions.
    task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic sf, output logic [31:0] r);
        logic [63:0] ux, uy, u;
        longint sx, sy, s;
        int kind, sh, cin, bw;
        logic nc, nv;
        ux = {32'd0, x}; uy = {32'd0, y};
        sx = $signed(x); sy = $signed(y);
        cin = int'(mflags[1]); bw = 1 - cin;
        nc = mflags[1]; nv = mflags[0];
        sh = int'(y[4:0]);
        kind = 1; r = 32'd0; s = 0;
        case (o)
            5'd0: begin u = ux + uy;       r = u[31:0]; nc = u[32]; s = sx + sy;       kind = 3; end
            5'd1: begin u = ux + uy + cin; r = u[31:0]; nc = u[32]; s = sx + sy + cin; kind = 3; end
            5'd2: begin r = x - y;                nc = (ux >= uy);      s = sx - sy;      kind = 3; end
            5'd3: begin r = x - y - 32'(bw);      nc = (ux >= uy + bw); s = sx - sy - bw; kind = 3; end
            5'd4: r = x & y;
            5'd5: r = x | y;
            5'd6: r = x ^ y;
            5'd7: r = ~(x ^ y);
            5'd8: r = x & ~y;
            5'd9: r = x | ~y;
            5'd10: begin r = x << sh; if (sh != 0) nc = x[32 - sh]; kind = 2; end
            5'd11: begin r = x >> sh; if (sh != 0) nc = x[sh - 1]; kind = 2; end
            5'd12: begin r = $signed(x) >>> sh; if (sh != 0) nc = x[sh - 1]; kind = 2; end
            5'd13: r = x;
            5'd14: r = y;
            5'd15: r = ~y;
            5'd16: begin u = ux * uy; r = u[31:0]; end
            default: begin r = 32'd0; kind = 0; end
        endcase
        nv = (kind == 3) ? ((s > 64'sd2147483647) || (s < -64'sd2147483648)) : nv;
        if (sf && kind > 0) begin
            mflags[3] = (r == 32'd0);
            mflags[2] = r[31];
            if (kind >= 2) mflags[1] = nc;
            if (kind == 3) mflags[0] = nv;
        end
    endtask

    // Present a request, wait for acceptance, record the expected response.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic sf, input int lat);
        exp_t e;
        int n;
        n = 0;
        in_valid = 1'b1; op = o; a = x; b = y; set_flags = sf;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("accept", in_ready, 1);
        if (in_ready) begin
            model(o, x, y, sf, e.res);
            e.fl = mflags; e.acc = cyc + 1; e.lat = lat;
            sbq.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("result", result, mon_e.res);
                check("flags", flags, mon_e.fl);
                if (mon_e.lat > 0) check("latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] corner [0:5];
        int busyc, rdy_busy, n;
        logic [4:0] o;
        logic [31:0] x, y;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'hFFFFFFFF; corner[5] = 32'h55AA00FF;
        reset = 1'b1; in_valid = 1'b0; op = 5'd0; a = '0; b = '0;
        set_flags = 1'b0; out_ready = 1'b1; mflags = 4'b0000;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 1);
        drain();
        check("add_ovf_flags", flags, 4'b0101);

        issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 1);
        issue(OP_ADC, 32'h0, 32'h0, 1'b0, 1);
        drain();

        issue(OP_MUL, 32'h00010001, 32'h00010001, 1'b0, 33);
        busyc = 0; rdy_busy = 0; n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            if (busy) busyc++;
            if (busy && in_ready) rdy_busy++;
            n++;
        end
        check("mul_busy_cycles", busyc, 32);
        check("mul_ready_in_calc", rdy_busy, 0);
        drain();

        issue(OP_ASR, 32'h80000010, 32'h4, 1'b1, 1);
        drain();

        out_ready = 1'b0;
        issue(OP_SUB, 32'h5, 32'h5, 1'b1, 0);
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, 0);
            check("hold_flags", flags, 4'b1010);
            check("hold_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", out_valid, 0);
        check("queue_after_hold", sbq.size(), 0);

        issue(OP_MUL, 32'h3, 32'h5, 1'b1, 33);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midmul_rst_valid", out_valid, 0);
        check("midmul_rst_busy", busy, 0);
        check("midmul_rst_flags", flags, 0);
        sbq.delete();
        mflags = 4'b0000;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", in_ready, 1);
        @(posedge clk); #1;
        issue(OP_ADD, 32'h2, 32'h3, 1'b0, 1);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            n = $urandom_range(0, 9);
            if (n == 0)      o = OP_MUL;
            else if (n == 1) o = 5'($urandom_range(17, 31));
            else             o = 5'($urandom_range(0, 15));
            x = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            issue(o, x, y, 1'($urandom_range(0, 1)), 0);
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin @(posedge clk); #1; end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
